// File: rtl/mdu_if.sv
// mdu_if: E-stage multiply/divide request bundle and HI/LO/busy results.
// Ports (signals): mdu_start, mdu_mod[2:0], in1[31:0], in2[31:0] from the pipeline;
//                  busy, hi[31:0], lo[31:0] back from the unit.
interface mdu_if;
   logic        mdu_start;
   logic [2:0]  mdu_mod;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   modport master (output mdu_start, mdu_mod, in1, in2, input busy, hi, lo);
   modport slave (input mdu_start, mdu_mod, in1, in2, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle signed/unsigned multiply/divide into HI/LO with mthi/mtlo.
// Ports: clk, reset (async, active-high), bus (mdu_if.slave: start/mod/in1/in2 in,
//        busy/hi/lo out; busy and hi/lo are plain register outputs).
module mdu (
   input logic clk,
   input logic reset,
   mdu_if.slave bus
);
   localparam logic [3:0] MUL_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES = 4'd10;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN = 1'b1;
   logic [0:0]  state;
   logic [3:0]  cnt;
   logic [31:0] a, b, hi_r, lo_r;
   logic [1:0]  op;
   logic [63:0] prod;
   logic [31:0] abs_a, abs_b, uq, ur, quo, rem;
   // Sign-extending before a 64-bit unsigned multiply yields the exact low 64 bits
   // of the signed product, so one multiplier covers both signednesses.
   assign prod = op[0] ? {32'b0, a} * {32'b0, b}
                       : {{32{a[31]}}, a} * {{32{b[31]}}, b};
   // Signed division runs on magnitudes and fixes signs afterward; this also makes
   // 0x80000000 / -1 fall out as LO = 0x80000000, HI = 0.
   assign abs_a = (!op[0] && a[31]) ? -a : a;
   assign abs_b = (!op[0] && b[31]) ? -b : b;
   assign uq = abs_a / abs_b;
   assign ur = abs_a % abs_b;
   assign quo = (!op[0] && (a[31] ^ b[31])) ? -uq : uq;
   assign rem = (!op[0] && a[31]) ? -ur : ur;
   assign bus.busy = state == RUN;
   assign bus.hi = hi_r;
   assign bus.lo = lo_r;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         a <= '0;
         b <= '0;
         op <= '0;
         hi_r <= '0;
         lo_r <= '0;
      end else if (state == IDLE) begin
         if (bus.mdu_start && !bus.mdu_mod[2]) begin
            a <= bus.in1;
            b <= bus.in2;
            op <= bus.mdu_mod[1:0];
            cnt <= bus.mdu_mod[1] ? DIV_CYCLES : MUL_CYCLES;
            state <= RUN;
         end else if (!bus.mdu_start && bus.mdu_mod == 3'b100) begin
            hi_r <= bus.in1;
         end else if (!bus.mdu_start && bus.mdu_mod == 3'b101) begin
            lo_r <= bus.in1;
         end
      end else begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            state <= IDLE;
            if (!op[1]) begin
               {hi_r, lo_r} <= prod;
            end else if (b != '0) begin
               hi_r <= rem;
               lo_r <= quo;
            end
         end
      end
   end
endmodule
